rcl_stim_driver: RTL and testbench
==================================

Name: rcl_stim_driver

Overview:
Initiator-side block for the circle/line relation checker (RCL) protocol. It accepts one test vector per command through a valid/ready handshake and serialises it onto the RCL input interface as three in_valid beats: line coefficients a, b, c on coef_L and circle terms m, n, k on coef_Q. It then waits for the one-cycle out_valid/out result, measures latency, enforces a timeout and flags protocol errors. The result comes back on a response port. It sits between the test/sequence controller and the RCL instance.

Parameters:
TIMEOUT, 100, maximum cycles to wait for out_valid after the last beat before aborting.
GAP, 1, minimum idle cycles (in_valid low) after a response before the next transaction's first beat.
LAT_W, 8, width of the latency counter; the counter saturates at all-ones.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command vector present
cmd_ready  out  1  driver can accept a command (high only in IDLE with the gap satisfied)
cmd_a, cmd_b, cmd_c  in  5 each  signed line coefficients (a*x + b*y + c = 0)
cmd_m, cmd_n  in  5 each  signed circle centre
cmd_k  in  5  unsigned radius squared
in_valid  out  1  to RCL; beat strobe
coef_L  out  5  to RCL; beats a, b, c
coef_Q  out  5  to RCL; beats m, n, k
out_valid  in  1  from RCL; result strobe
out  in  2  from RCL; 0 = disjoint, 1 = tangent, 2 = intersect, 3 = reserved
rsp_valid  out  1  one-cycle response strobe
rsp_result  out  2  captured RCL result
rsp_latency  out  LAT_W  cycles from first post-beat cycle to out_valid, inclusive
rsp_err  out  2  0 = ok, 1 = timeout, 2 = out_valid during SEND, 3 = reserved code received

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs go to 0 on reset: cmd_ready, in_valid, coef_L, coef_Q, rsp_*.
  - State goes to IDLE.
  - The gap counter is preloaded to GAP, so cmd_ready rises GAP cycles after reset release.
  - Reset mid-transaction drops in_valid immediately. No response is issued for the aborted command.
- All outputs are registered.
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE:
  - cmd_ready = 1 when the gap counter is 0.
  - On cmd_valid & cmd_ready, latch all six coefficients, set beat = 0 and go to SEND.
  - The first beat appears on the cycle after acceptance.
- SEND:
  - in_valid = 1 for exactly 3 consecutive cycles.
  - Beat 0 drives coef_L = a, coef_Q = m.
  - Beat 1 drives coef_L = b, coef_Q = n.
  - Beat 2 drives coef_L = c, coef_Q = k.
  - After beat 2, go to WAIT. in_valid falls and coef_L/coef_Q return to 0 on the next cycle.
  - out_valid sampled high in SEND: record err = 2, finish the remaining beats, then go directly to RESP.
- WAIT:
  - The latency counter starts at 1 on the first WAIT cycle and increments each cycle, saturating.
  - out_valid = 1: capture out into rsp_result and go to RESP.
    - If out == 3, also set err = 3.
  - The counter reaching TIMEOUT with no out_valid: set err = 1, rsp_result = 0, go to RESP.
  - out_valid arriving on the same cycle the timeout hits counts as success; out_valid has priority.
- RESP:
  - rsp_valid = 1 for one cycle, with rsp_result, rsp_latency and rsp_err stable.
  - Then return to IDLE and load the gap counter with GAP.
  - rsp_* fields hold their values until the next RESP. Only rsp_valid clears.
- out_valid seen in IDLE or RESP is ignored and produces no response.
- The coefficient registers are frozen from acceptance until the return to IDLE. Changes on cmd_* during a transaction have no effect.
- Back-to-back throughput: one transaction per 3 + latency + 1 + GAP + 1 cycles.

Decomposition:
- Shared package rcl_pkg holds:
  - result codes RCL_DISJOINT = 0, RCL_TANGENT = 1, RCL_INTERSECT = 2;
  - error codes ERR_OK, ERR_TIMEOUT, ERR_EARLY, ERR_CODE;
  - state enum {IDLE, SEND, WAIT, RESP};
  - the beat count constant RCL_BEATS = 3.
- One natural sub-module is rcl_beat_mux: a registered 3-to-1 selector of (a, m), (b, n), (c, k) by beat index.
- Counters and the FSM stay in the top level.

Test Plan:
- Tangent case: cmd a=1, b=0, c=0, m=3, n=0, k=9; responder returns out=1 six cycles after the last beat. Required: beats (1,3), (0,0), (0,9); rsp_result = 1, rsp_latency = 6, rsp_err = 0.
- Intersect with negative coefficients: a=-1, b=1, c=0, m=0, n=0, k=4; responder returns out=2 at latency 3. Required: coef_L beats show 5'b11111, 1, 0; rsp_result = 2, rsp_err = 0.
- Timeout: TIMEOUT=10 and the responder never asserts out_valid. Required: rsp_valid exactly 10 cycles after the last beat, rsp_err = 1, rsp_result = 0; the next cmd_ready appears GAP cycles after that.
- Early and reserved result:
  - out_valid pulsed during beat 1 gives all 3 beats, then rsp_err = 2.
  - A separate run returning out=3 gives rsp_err = 3.
- Back-to-back commands with cmd_valid held high, GAP=2: at least 2 in_valid-low cycles between RESP and the next first beat; the second vector's coefficients are sent correctly.
- Reset asserted during beat 1: in_valid drops asynchronously and no rsp_valid appears. After release, a new command completes normally.

Source files
------------

// File: rtl/rcl_pkg.sv
`default_nettype none
// rcl_pkg: result/error codes, FSM state encoding and beat count shared by the RCL stimulus driver.
// Revision: 1.0
package rcl_pkg;

  localparam logic [1:0] RCL_DISJOINT  = 2'd0;
  localparam logic [1:0] RCL_TANGENT   = 2'd1;
  localparam logic [1:0] RCL_INTERSECT = 2'd2;
  localparam logic [1:0] RCL_RESERVED  = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_EARLY   = 2'd2;
  localparam logic [1:0] ERR_CODE    = 2'd3;

  localparam int RCL_BEATS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } rcl_state_e;

endpackage
`default_nettype wire

// File: rtl/rcl_beat_mux.sv
`default_nettype none
// rcl_beat_mux: registered selector of (a,m) / (b,n) / (c,k) by beat index; drives zeros when idle.
// Revision: 1.0
module rcl_beat_mux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic [4:0] c,
  input  logic [4:0] m,
  input  logic [4:0] n,
  input  logic [4:0] k,
  output logic [4:0] coef_l,
  output logic [4:0] coef_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_l <= '0;
      coef_q <= '0;
    end else if (!en) begin
      coef_l <= '0;
      coef_q <= '0;
    end else begin
      case (sel)
        2'd0:    begin coef_l <= a; coef_q <= m; end
        2'd1:    begin coef_l <= b; coef_q <= n; end
        default: begin coef_l <= c; coef_q <= k; end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rcl_stim_driver.sv
`default_nettype none
// rcl_stim_driver: serialises one command into three RCL beats, then collects the result with latency/timeout/error tracking.
// Revision: 1.0
module rcl_stim_driver
  import rcl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100,
  parameter int unsigned GAP     = 1,
  parameter int unsigned LAT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_a,
  input  logic [4:0]       cmd_b,
  input  logic [4:0]       cmd_c,
  input  logic [4:0]       cmd_m,
  input  logic [4:0]       cmd_n,
  input  logic [4:0]       cmd_k,
  output logic             in_valid,
  output logic [4:0]       coef_L,
  output logic [4:0]       coef_Q,
  input  logic             out_valid,
  input  logic [1:0]       out,
  output logic             rsp_valid,
  output logic [1:0]       rsp_result,
  output logic [LAT_W-1:0] rsp_latency,
  output logic [1:0]       rsp_err
);

  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  rcl_state_e       state, state_next;
  logic [1:0]       beat, beat_next;
  logic             early, early_next;
  logic [LAT_W-1:0] lat, lat_next, lat_inc;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [4:0]       a_q, b_q, c_q, m_q, n_q, k_q;
  logic             accept;
  logic             rsp_load;
  logic [1:0]       res_next, err_next;
  logic [LAT_W-1:0] rlat_next;
  logic             timeout_hit;

  assign lat_inc     = (&lat) ? lat : lat + LAT_W'(1);
  assign timeout_hit = 32'(lat_inc) >= 32'(TIMEOUT);

  always_comb begin
    state_next = state;
    beat_next  = beat;
    early_next = early;
    lat_next   = lat;
    gap_next   = gap_cnt;
    accept     = 1'b0;
    rsp_load   = 1'b0;
    res_next   = rsp_result;
    err_next   = rsp_err;
    rlat_next  = rsp_latency;
    unique case (state)
      IDLE: begin
        if (gap_cnt != '0) gap_next = gap_cnt - GAP_W'(1);
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = SEND;
          beat_next  = 2'd0;
          early_next = 1'b0;
        end
      end
      SEND: begin
        if (out_valid) early_next = 1'b1;
        if (beat == 2'(RCL_BEATS - 1)) begin
          if (early_next) begin
            state_next = RESP;
            rsp_load   = 1'b1;
            res_next   = RCL_DISJOINT;
            err_next   = ERR_EARLY;
            rlat_next  = '0;
          end else begin
            state_next = WAIT;
            lat_next   = LAT_W'(1);
          end
        end else begin
          beat_next = beat + 2'd1;
        end
      end
      WAIT: begin
        lat_next = lat_inc;
        // A result on the timeout cycle still counts as a success.
        if (out_valid) begin
          state_next = RESP;
          rsp_load   = 1'b1;
          res_next   = out;
          err_next   = (out == RCL_RESERVED) ? ERR_CODE : ERR_OK;
          rlat_next  = lat;
        end else if (timeout_hit) begin
          state_next = RESP;
          rsp_load   = 1'b1;
          res_next   = RCL_DISJOINT;
          err_next   = ERR_TIMEOUT;
          rlat_next  = lat_inc;
        end
      end
      RESP: begin
        state_next = IDLE;
        gap_next   = GAP_W'(GAP);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= 2'd0;
      early       <= 1'b0;
      lat         <= '0;
      gap_cnt     <= GAP_W'(GAP);
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      cmd_ready   <= 1'b0;
      in_valid    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_latency <= '0;
      rsp_err     <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      early     <= early_next;
      lat       <= lat_next;
      gap_cnt   <= gap_next;
      if (accept) begin
        a_q <= cmd_a;
        b_q <= cmd_b;
        c_q <= cmd_c;
        m_q <= cmd_m;
        n_q <= cmd_n;
        k_q <= cmd_k;
      end
      cmd_ready <= (state_next == IDLE) && (gap_next == '0);
      in_valid  <= (state_next == SEND);
      rsp_valid <= rsp_load;
      if (rsp_load) begin
        rsp_result  <= res_next;
        rsp_err     <= err_next;
        rsp_latency <= rlat_next;
      end
    end
  end

  // Beat 0 is registered on the acceptance edge, so a/m bypass the holding registers.
  rcl_beat_mux u_beat_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_next == SEND),
    .sel    (beat_next),
    .a      (accept ? cmd_a : a_q),
    .b      (b_q),
    .c      (c_q),
    .m      (accept ? cmd_m : m_q),
    .n      (n_q),
    .k      (k_q),
    .coef_l (coef_L),
    .coef_q (coef_Q)
  );

endmodule
`default_nettype wire

// File: tb/tb_rcl_stim_driver.sv
`default_nettype none
// tb_rcl_stim_driver: scoreboard bench with a scripted RCL responder model for rcl_stim_driver.
// Revision: 1.0
module tb_rcl_stim_driver;

  localparam int GAP_P     = 2;
  localparam int TIMEOUT_P = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_a = '0, cmd_b = '0, cmd_c = '0, cmd_m = '0, cmd_n = '0, cmd_k = '0;
  logic       in_valid;
  logic [4:0] coef_L, coef_Q;
  logic       out_valid = 1'b0;
  logic [1:0] out = '0;
  logic       rsp_valid;
  logic [1:0] rsp_result;
  logic [7:0] rsp_latency;
  logic [1:0] rsp_err;

  rcl_stim_driver #(.TIMEOUT(TIMEOUT_P), .GAP(GAP_P), .LAT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .cmd_m(cmd_m), .cmd_n(cmd_n), .cmd_k(cmd_k),
    .in_valid(in_valid), .coef_L(coef_L), .coef_Q(coef_Q),
    .out_valid(out_valid), .out(out),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_latency(rsp_latency), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] res;
    logic [1:0] err;
    logic [7:0] lat;
    logic       chk_res;
    logic       chk_lat;
  } rsp_t;

  logic [9:0] exp_beats[$];
  rsp_t       exp_rsp[$];
  logic [9:0] eb;
  rsp_t       er;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int rsp_cyc = 0;
  int last_beat_cyc = 0;
  int first_beat_cyc = 0;
  int prev_first_beat_cyc = 0;
  logic prev_iv = 1'b0;

  // Responder script: -1 disables the corresponding action.
  int resp_delay = -1;
  int resp_code = 0;
  int early_beat = -1;
  int nbeats = 0;
  int wcnt = 0;

  always @(posedge clk) cyc++;

  // RCL responder model: counts beats, then answers resp_delay cycles after the last one.
  always begin
    @(posedge clk);
    #1;
    out_valid = 1'b0;
    out = 2'd0;
    if (!rst_n || rsp_valid) begin
      nbeats = 0;
      wcnt = 0;
    end else if (in_valid) begin
      if (nbeats == early_beat) begin
        out_valid = 1'b1;
        out = 2'd2;
      end
      nbeats++;
      wcnt = 0;
    end else if (nbeats == 3) begin
      wcnt++;
      if (wcnt == resp_delay) begin
        out_valid = 1'b1;
        out = 2'(resp_code);
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid) begin
        total++;
        if (exp_beats.size() == 0) begin
          bad++;
          $display("FAIL beat_extra: got L=%b Q=%b, no beat expected", coef_L, coef_Q);
        end else begin
          eb = exp_beats.pop_front();
          if ({coef_L, coef_Q} !== eb) begin
            bad++;
            $display("FAIL beat: got L=%b Q=%b required L=%b Q=%b", coef_L, coef_Q, eb[9:5], eb[4:0]);
          end
        end
        if (!prev_iv) begin
          prev_first_beat_cyc = first_beat_cyc;
          first_beat_cyc = cyc;
        end
        last_beat_cyc = cyc;
      end else if (prev_iv) begin
        total++;
        if (coef_L !== 5'd0 || coef_Q !== 5'd0) begin
          bad++;
          $display("FAIL beat_idle: got L=%b Q=%b required 0 0", coef_L, coef_Q);
        end
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        rsp_seen++;
        total++;
        if (exp_rsp.size() == 0) begin
          bad++;
          $display("FAIL rsp_extra: got result=%0d err=%0d, no response expected", rsp_result, rsp_err);
        end else begin
          er = exp_rsp.pop_front();
          if (rsp_err !== er.err || (er.chk_res && rsp_result !== er.res) ||
              (er.chk_lat && rsp_latency !== er.lat)) begin
            bad++;
            $display("FAIL rsp: got result=%0d err=%0d lat=%0d required result=%0d err=%0d lat=%0d",
                     rsp_result, rsp_err, rsp_latency, er.res, er.err, er.lat);
          end
        end
      end
    end
    prev_iv = in_valid;
  end

  task automatic expect_rsp(input logic [1:0] res, input logic [1:0] err, input logic [7:0] lat,
                            input logic chk_res, input logic chk_lat);
    rsp_t r;
    r.res = res; r.err = err; r.lat = lat; r.chk_res = chk_res; r.chk_lat = chk_lat;
    exp_rsp.push_back(r);
  endtask

  // Presents a command and returns in the cycle of beat 0; cmd_valid is left high.
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [4:0] m, input logic [4:0] n, input logic [4:0] k);
    @(posedge clk);
    #1;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_m = m; cmd_n = n; cmd_k = k;
    cmd_valid = 1'b1;
    exp_beats.push_back({a, m});
    exp_beats.push_back({b, n});
    exp_beats.push_back({c, k});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_ready_wait: got 0 required 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (rsp_seen != n0) break;
    end
    total++;
    if (rsp_seen == n0) begin
      bad++;
      $display("FAIL rsp_wait: got no rsp_valid required one within 60 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, in_valid, coef_L, coef_Q, rsp_valid, rsp_result, rsp_latency, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b iv=%b L=%b Q=%b rv=%b res=%0d lat=%0d err=%0d required all 0",
               cmd_ready, in_valid, coef_L, coef_Q, rsp_valid, rsp_result, rsp_latency, rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_gap_low: got cmd_ready=%b required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_gap_ready: got cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_tangent;
    int n0;
    resp_delay = 6; resp_code = 1; early_beat = -1;
    expect_rsp(2'd1, 2'd0, 8'd6, 1'b1, 1'b1);
    n0 = rsp_seen;
    issue(5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd9);
    cmd_valid = 1'b0;
    wait_rsp(n0);
    total++;
    if (rsp_cyc - last_beat_cyc != 7) begin
      bad++;
      $display("FAIL tangent_timing: got rsp %0d cycles after last beat required 7", rsp_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_intersect_neg;
    int n0;
    resp_delay = 3; resp_code = 2; early_beat = -1;
    expect_rsp(2'd2, 2'd0, 8'd3, 1'b1, 1'b1);
    n0 = rsp_seen;
    issue(5'h1F, 5'd1, 5'd0, 5'd0, 5'd0, 5'd4);
    cmd_valid = 1'b0;
    wait_rsp(n0);
  endtask

  task automatic test_timeout;
    int n0;
    int ready_cyc;
    resp_delay = -1; resp_code = 0; early_beat = -1;
    expect_rsp(2'd0, 2'd1, 8'd0, 1'b1, 1'b0);
    n0 = rsp_seen;
    issue(5'd2, 5'd2, 5'd2, 5'd1, 5'd1, 5'd1);
    cmd_valid = 1'b0;
    wait_rsp(n0);
    total++;
    if (rsp_cyc - last_beat_cyc != TIMEOUT_P) begin
      bad++;
      $display("FAIL timeout_timing: got rsp %0d cycles after last beat required %0d",
               rsp_cyc - last_beat_cyc, TIMEOUT_P);
    end
    ready_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (cmd_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    // GAP idle cycles after RESP, then the acceptance cycle with cmd_ready high.
    total++;
    if (ready_cyc - rsp_cyc != GAP_P + 1) begin
      bad++;
      $display("FAIL timeout_gap: got cmd_ready %0d cycles after rsp required %0d", ready_cyc - rsp_cyc, GAP_P + 1);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_err !== 2'd1 || rsp_result !== 2'd0) begin
      bad++;
      $display("FAIL rsp_hold: got rv=%b err=%0d res=%0d required rv=0 err=1 res=0", rsp_valid, rsp_err, rsp_result);
    end
  endtask

  task automatic test_early_reserved;
    int n0;
    resp_delay = -1; resp_code = 0; early_beat = 1;
    expect_rsp(2'd0, 2'd2, 8'd0, 1'b0, 1'b0);
    n0 = rsp_seen;
    issue(5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8);
    cmd_valid = 1'b0;
    wait_rsp(n0);
    total++;
    if (rsp_cyc - last_beat_cyc != 1) begin
      bad++;
      $display("FAIL early_timing: got rsp %0d cycles after last beat required 1", rsp_cyc - last_beat_cyc);
    end
    resp_delay = 4; resp_code = 3; early_beat = -1;
    expect_rsp(2'd3, 2'd3, 8'd4, 1'b1, 1'b1);
    n0 = rsp_seen;
    issue(5'h1E, 5'h1D, 5'd1, 5'd2, 5'h1F, 5'd16);
    cmd_valid = 1'b0;
    wait_rsp(n0);
  endtask

  task automatic test_back_to_back;
    int n0;
    int f1, f2;
    resp_delay = 2; resp_code = 2; early_beat = -1;
    expect_rsp(2'd2, 2'd0, 8'd2, 1'b1, 1'b1);
    expect_rsp(2'd2, 2'd0, 8'd2, 1'b1, 1'b1);
    issue(5'd2, 5'h1D, 5'd5, 5'h1E, 5'd7, 5'd15);
    // cmd_valid stays high; the next vector is presented while the first is in flight.
    issue(5'h10, 5'd15, 5'h1F, 5'd1, 5'h18, 5'd31);
    n0 = rsp_seen;
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    f1 = prev_first_beat_cyc;
    f2 = first_beat_cyc;
    total++;
    if (f2 - f1 != 3 + 2 + 1 + GAP_P + 1) begin
      bad++;
      $display("FAIL b2b_period: got %0d cycles between first beats required %0d", f2 - f1, 3 + 2 + 1 + GAP_P + 1);
    end
    total++;
    if (f2 - rsp_cyc - 1 < GAP_P) begin
      bad++;
      $display("FAIL b2b_gap: got %0d in_valid-low cycles after rsp required at least %0d", f2 - rsp_cyc - 1, GAP_P);
    end
    wait_rsp(n0);
  endtask

  task automatic test_reset_mid;
    int n0;
    resp_delay = 5; resp_code = 1; early_beat = -1;
    n0 = rsp_seen;
    issue(5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_beat1: got in_valid=%b required 1", in_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_valid !== 1'b0 || coef_L !== 5'd0 || coef_Q !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got iv=%b L=%b Q=%b required 0 0 0", in_valid, coef_L, coef_Q);
    end
    exp_beats.delete();
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (rsp_seen != n0) begin
      bad++;
      $display("FAIL reset_mid_norsp: got %0d responses required 0", rsp_seen - n0);
    end
    resp_delay = 2; resp_code = 0;
    expect_rsp(2'd0, 2'd0, 8'd2, 1'b1, 1'b1);
    n0 = rsp_seen;
    issue(5'd1, 5'd1, 5'h1E, 5'd0, 5'd0, 5'd1);
    cmd_valid = 1'b0;
    wait_rsp(n0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tangent();
    test_intersect_neg();
    test_timeout();
    test_early_reserved();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_beats.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d beats %0d responses outstanding required 0 0", exp_beats.size(), exp_rsp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
